// File: rtl/output_accum_ctrl_pkg.sv
// Shared definitions for the output accumulation controller: FSM state encoding and default sizing.
package output_pkg;

    localparam int N_COLS_ARRAY_DEF     = 16;
    localparam int NUMBER_MUX_OUT_1_DEF = 4;
    localparam int BRAM_ADDR_WIDTH_DEF  = 15;
    localparam int PIX_WIDTH_DEF        = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_CAPTURE,
        ST_SWEEP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/output_accum_ctrl_if.sv
// Upstream handshake between the systolic array result bus and the accumulation controller.
interface output_accum_ctrl_if
    import output_pkg::*;
#(
    parameter int N_COLS_ARRAY = N_COLS_ARRAY_DEF,
    parameter int PIX_WIDTH    = PIX_WIDTH_DEF
) ();

    logic                              start_i;
    logic                              clear_i;
    logic [$clog2(N_COLS_ARRAY+1)-1:0] n_active_cols_i;
    logic [PIX_WIDTH-1:0]              n_pixels_i;
    logic                              busy_o;
    logic                              data_ack_o;
    logic                              pass_done_o;

    modport master (
        output start_i, clear_i, n_active_cols_i, n_pixels_i,
        input  busy_o, data_ack_o, pass_done_o
    );

    modport slave (
        input  start_i, clear_i, n_active_cols_i, n_pixels_i,
        output busy_o, data_ack_o, pass_done_o
    );

endinterface

// File: rtl/output_accum_ctrl_addr_gen.sv
// Turns (pixel, mux group, mux input) into a BRAM read address and delays it one cycle for the write port.
module output_addr_gen
    import output_pkg::*;
#(
    parameter int N_COLS_ARRAY           = N_COLS_ARRAY_DEF,
    parameter int NUMBER_INPUT_MUX_OUT_1 = 4,
    parameter int SEL_WIDTH_MUX_OUT_1    = 3,
    parameter int SEL_WIDTH_MUX_OUT_2    = 2,
    parameter int BRAM_ADDR_WIDTH        = BRAM_ADDR_WIDTH_DEF,
    parameter int PIX_WIDTH              = PIX_WIDTH_DEF,
    parameter int NCOL_W                 = $clog2(N_COLS_ARRAY + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           slot_vld,
    input  logic [PIX_WIDTH-1:0]           pix,
    input  logic [SEL_WIDTH_MUX_OUT_2-1:0] g,
    input  logic [SEL_WIDTH_MUX_OUT_1-1:0] s1,
    input  logic [NCOL_W-1:0]              n_active_cols,
    output logic [BRAM_ADDR_WIDTH-1:0]     rd_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]     wr_addr,
    output logic                           wr_en
);

    logic [31:0] col;
    logic        col_active;

    // Mux input 0 is the zero input, so real columns start at select value 1.
    assign col        = 32'(g) * 32'(NUMBER_INPUT_MUX_OUT_1) + 32'(s1) - 32'd1;
    assign col_active = col < 32'(n_active_cols);
    assign rd_addr    = BRAM_ADDR_WIDTH'(32'(pix) * 32'(N_COLS_ARRAY) + col);

    // The BRAM read data plus column result lands one cycle later, so the write follows the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= slot_vld && col_active;
            if (slot_vld) begin
                wr_addr <= rd_addr;
            end
        end
    end

endmodule

// File: rtl/output_accum_ctrl.sv
// Output accumulation controller: walks the two-level column mux tree and read-modify-writes the BRAM per pixel.
// Define OUTPUT_ACCUM_CTRL_CLEAR_EN to build the BRAM zero-fill (CLEAR) sweep.
module output_accum_ctrl
    import output_pkg::*;
#(
    parameter int N_COLS_ARRAY           = N_COLS_ARRAY_DEF,
    parameter int NUMBER_MUX_OUT_1       = NUMBER_MUX_OUT_1_DEF,
    parameter int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1,
    parameter int SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1),
    parameter int SEL_WIDTH_MUX_OUT_2    = $clog2(NUMBER_MUX_OUT_1),
    parameter int BRAM_ADDR_WIDTH        = BRAM_ADDR_WIDTH_DEF,
    parameter int PIX_WIDTH              = PIX_WIDTH_DEF
) (
    input  logic                           clk_i,
    input  logic                           sel_mux_rst_i,
    output_accum_ctrl_if.slave             bus,
    output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o,
    output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o,
    output logic                           sel_mux_ld_o,
    output logic                           reg_rst_o,
    output logic                           reg_wr_en_o,
    output logic                           bram_wr_en_a_o,
    output logic                           bram_wr_en_b_o,
    output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_a_o,
    output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_b_o
);

    localparam int NCOL_W = $clog2(N_COLS_ARRAY + 1);
    localparam logic [SEL_WIDTH_MUX_OUT_1-1:0] S1_FIRST = SEL_WIDTH_MUX_OUT_1'(1);
    localparam logic [SEL_WIDTH_MUX_OUT_1-1:0] S1_LAST  = SEL_WIDTH_MUX_OUT_1'(NUMBER_INPUT_MUX_OUT_1);
    localparam logic [SEL_WIDTH_MUX_OUT_2-1:0] G_ONE    = SEL_WIDTH_MUX_OUT_2'(1);
    localparam logic [SEL_WIDTH_MUX_OUT_2-1:0] G_LAST   = SEL_WIDTH_MUX_OUT_2'(NUMBER_MUX_OUT_1 - 1);

    state_t                         state_q, state_d;
    logic [SEL_WIDTH_MUX_OUT_1-1:0] s1_q;
    logic [SEL_WIDTH_MUX_OUT_2-1:0] g_q;
    logic [PIX_WIDTH-1:0]           pix_q;
    logic [PIX_WIDTH-1:0]           pix_last;
    logic                           pix_wrap;
    logic                           reg_rst_q;
    logic                           clear_req;
    logic                           clr_done;
    logic [BRAM_ADDR_WIDTH-1:0]     clr_addr_q;
    logic                           slot_vld;
    logic [BRAM_ADDR_WIDTH-1:0]     rd_addr;
    logic                           data_ack;
    logic                           pass_done;

    // A zero pixel count is treated as a single-pixel pass.
    assign pix_last = (bus.n_pixels_i == '0) ? '0 : bus.n_pixels_i - PIX_WIDTH'(1);
    assign pix_wrap = (pix_q == pix_last);

`ifdef OUTPUT_ACCUM_CTRL_CLEAR_EN
    logic [PIX_WIDTH-1:0] n_pix_eff;
    logic [31:0]          clr_last;

    assign clear_req = bus.clear_i;
    assign n_pix_eff = (bus.n_pixels_i == '0) ? PIX_WIDTH'(1) : bus.n_pixels_i;
    assign clr_last  = 32'(n_pix_eff) * 32'(N_COLS_ARRAY) - 32'd1;
    assign clr_done  = (32'(clr_addr_q) == clr_last);
    assign bram_wr_en_b_o = (state_q == ST_CLEAR);

    always_ff @(posedge clk_i or posedge sel_mux_rst_i) begin
        if (sel_mux_rst_i) begin
            clr_addr_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_addr_q <= clr_addr_q + BRAM_ADDR_WIDTH'(1);
        end else begin
            clr_addr_q <= '0;
        end
    end
`else
    logic unused_clear;

    assign unused_clear   = bus.clear_i;
    assign clear_req      = 1'b0;
    assign clr_done       = 1'b1;
    assign clr_addr_q     = '0;
    assign bram_wr_en_b_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge sel_mux_rst_i) begin
        if (sel_mux_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (bus.start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SWEEP;
            ST_SWEEP: begin
                if (g_q == G_LAST) begin
                    state_d = (s1_q < S1_LAST) ? ST_LOAD : ST_DRAIN;
                end
            end
            ST_DRAIN:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_mux_out_1_o = '0;
        sel_mux_out_2_o = '0;
        sel_mux_ld_o    = 1'b0;
        reg_wr_en_o     = 1'b0;
        bram_addr_b_o   = '0;
        slot_vld        = 1'b0;
        data_ack        = 1'b0;
        pass_done       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                bram_addr_b_o = clr_addr_q;
            end
            ST_LOAD: begin
                sel_mux_ld_o    = 1'b1;
                sel_mux_out_1_o = s1_q;
            end
            ST_CAPTURE: begin
                reg_wr_en_o = 1'b1;
            end
            ST_SWEEP: begin
                sel_mux_ld_o    = 1'b1;
                sel_mux_out_1_o = s1_q;
                sel_mux_out_2_o = g_q;
                bram_addr_b_o   = rd_addr;
                slot_vld        = 1'b1;
            end
            ST_DRAIN: begin
                data_ack  = 1'b1;
                pass_done = pix_wrap;
            end
            default: ;
        endcase
    end

    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.data_ack_o  = data_ack;
    assign bus.pass_done_o = pass_done;
    assign reg_rst_o       = reg_rst_q;

    // s1 selects the mux input (1-based), g the mux group; pix survives between starts.
    always_ff @(posedge clk_i or posedge sel_mux_rst_i) begin
        if (sel_mux_rst_i) begin
            s1_q  <= S1_FIRST;
            g_q   <= '0;
            pix_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s1_q <= S1_FIRST;
                    g_q  <= '0;
                end
                ST_CLEAR: begin
                    if (clr_done) begin
                        pix_q <= '0;
                    end
                end
                ST_CAPTURE: begin
                    g_q <= '0;
                end
                ST_SWEEP: begin
                    if (g_q == G_LAST) begin
                        g_q <= '0;
                        if (s1_q < S1_LAST) begin
                            s1_q <= s1_q + S1_FIRST;
                        end
                    end else begin
                        g_q <= g_q + G_ONE;
                    end
                end
                ST_DRAIN: begin
                    s1_q  <= S1_FIRST;
                    pix_q <= pix_wrap ? '0 : pix_q + PIX_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Holds the column registers in reset until the first edge after reset release.
    always_ff @(posedge clk_i or posedge sel_mux_rst_i) begin
        if (sel_mux_rst_i) begin
            reg_rst_q <= 1'b1;
        end else begin
            reg_rst_q <= 1'b0;
        end
    end

    output_addr_gen #(
        .N_COLS_ARRAY           (N_COLS_ARRAY),
        .NUMBER_INPUT_MUX_OUT_1 (NUMBER_INPUT_MUX_OUT_1),
        .SEL_WIDTH_MUX_OUT_1    (SEL_WIDTH_MUX_OUT_1),
        .SEL_WIDTH_MUX_OUT_2    (SEL_WIDTH_MUX_OUT_2),
        .BRAM_ADDR_WIDTH        (BRAM_ADDR_WIDTH),
        .PIX_WIDTH              (PIX_WIDTH),
        .NCOL_W                 (NCOL_W)
    ) u_addr_gen (
        .clk           (clk_i),
        .rst           (sel_mux_rst_i),
        .slot_vld      (slot_vld),
        .pix           (pix_q),
        .g             (g_q),
        .s1            (s1_q),
        .n_active_cols (bus.n_active_cols_i),
        .rd_addr       (rd_addr),
        .wr_addr       (bram_addr_a_o),
        .wr_en         (bram_wr_en_a_o)
    );

endmodule

// File: tb/tb_output_accum_ctrl.sv
// Scoreboard bench for output_accum_ctrl: stimulus queues expected events, a negedge monitor pops and compares.
module tb_output_accum_ctrl;
    import output_pkg::*;

    localparam int NC  = 16;
    localparam int NM  = 4;
    localparam int NI  = 4;
    localparam int AW  = 15;
    localparam int PW  = 10;
    localparam int S1W = 3;
    localparam int S2W = 2;

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S1W-1:0] sel1;
    logic [S2W-1:0] sel2;
    logic           sel_ld, reg_rst, reg_wr_en, wr_en_a, wr_en_b;
    logic [AW-1:0]  addr_a, addr_b;

    output_accum_ctrl_if #(.N_COLS_ARRAY(NC), .PIX_WIDTH(PW)) bus ();

    output_accum_ctrl #(
        .N_COLS_ARRAY     (NC),
        .NUMBER_MUX_OUT_1 (NM),
        .BRAM_ADDR_WIDTH  (AW),
        .PIX_WIDTH        (PW)
    ) dut (
        .clk_i           (clk),
        .sel_mux_rst_i   (rst),
        .bus             (bus),
        .sel_mux_out_1_o (sel1),
        .sel_mux_out_2_o (sel2),
        .sel_mux_ld_o    (sel_ld),
        .reg_rst_o       (reg_rst),
        .reg_wr_en_o     (reg_wr_en),
        .bram_wr_en_a_o  (wr_en_a),
        .bram_wr_en_b_o  (wr_en_b),
        .bram_addr_a_o   (addr_a),
        .bram_addr_b_o   (addr_b)
    );

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  pix_m = 0;
    ev_t q_sel[$], q_cap[$], q_wa[$], q_wb[$], q_ack[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int a, input int b, input int d);
        ev_t e;
        e.cyc = c; e.a = a; e.b = b; e.c = d;
        return e;
    endfunction

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic take(input int k, output ev_t e, output bit got);
        got = 1'b0;
        e = mk(0, 0, 0, 0);
        case (k)
            0: if (q_sel.size() > 0) begin e = q_sel.pop_front(); got = 1'b1; end
            1: if (q_cap.size() > 0) begin e = q_cap.pop_front(); got = 1'b1; end
            2: if (q_wa.size()  > 0) begin e = q_wa.pop_front();  got = 1'b1; end
            3: if (q_wb.size()  > 0) begin e = q_wb.pop_front();  got = 1'b1; end
            default: if (q_ack.size() > 0) begin e = q_ack.pop_front(); got = 1'b1; end
        endcase
    endtask

    task automatic flush();
        q_sel.delete(); q_cap.delete(); q_wa.delete(); q_wb.delete(); q_ack.delete();
    endtask

    // Reference sequence: LOAD, CAPTURE, NM sweep slots per mux input; writes one cycle after each read.
    task automatic push_pass(input int c0, input int nact, input int npix);
        int  last;
        bit  pd;
        for (int s = 1; s <= NI; s++) begin
            int b;
            b = c0 + 1 + (s - 1) * (NM + 2);
            q_sel.push_back(mk(b, s, 0, -1));
            q_cap.push_back(mk(b + 1, 0, 0, 0));
            for (int g = 0; g < NM; g++) begin
                int col, addr;
                col  = g * NI + s - 1;
                addr = (pix_m * NC + col) % (1 << AW);
                q_sel.push_back(mk(b + 2 + g, s, g, addr));
                if (col < nact) q_wa.push_back(mk(b + 3 + g, addr, 0, 0));
            end
        end
        last = (npix == 0) ? 0 : npix - 1;
        pd   = (pix_m == last);
        q_ack.push_back(mk(c0 + 25, int'(pd), 0, 0));
        pix_m = pd ? 0 : pix_m + 1;
    endtask

    task automatic run_pass(input int nact, input int npix, input int extra);
        int c0;
        @(negedge clk);
        bus.n_active_cols_i = 5'(nact);
        bus.n_pixels_i      = 10'(npix);
        bus.start_i         = 1'b1;
        c0 = cyc;
        push_pass(c0, nact, npix);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus.start_i = (extra > 0) && (cyc == c0 + extra);
        end
        chk("idle_after_pass", bus.busy_o == 1'b0, int'(bus.busy_o), 0);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        bit  got;
        if (!rst) begin
            if (sel_ld) begin
                take(0, e, got);
                if (!got) chk("sel_unexpected", 1'b0, int'(sel1), -1);
                else begin
                    chk("sel_cycle", cyc == e.cyc, cyc, e.cyc);
                    chk("sel_mux_out_1", int'(sel1) == e.a, int'(sel1), e.a);
                    chk("sel_mux_out_2", int'(sel2) == e.b, int'(sel2), e.b);
                    if (e.c >= 0) chk("rd_addr_b", int'(addr_b) == e.c, int'(addr_b), e.c);
                end
            end
            if (reg_wr_en) begin
                take(1, e, got);
                if (!got) chk("capture_unexpected", 1'b0, cyc, -1);
                else chk("capture_cycle", cyc == e.cyc, cyc, e.cyc);
            end
            if (wr_en_a) begin
                take(2, e, got);
                if (!got) chk("wr_a_unexpected", 1'b0, int'(addr_a), -1);
                else begin
                    chk("wr_a_cycle", cyc == e.cyc, cyc, e.cyc);
                    chk("wr_a_addr", int'(addr_a) == e.a, int'(addr_a), e.a);
                end
            end
            if (wr_en_b) begin
                take(3, e, got);
                if (!got) chk("wr_b_unexpected", 1'b0, int'(addr_b), -1);
                else begin
                    chk("wr_b_cycle", cyc == e.cyc, cyc, e.cyc);
                    chk("wr_b_addr", int'(addr_b) == e.a, int'(addr_b), e.a);
                end
            end
            if (bus.data_ack_o) begin
                take(4, e, got);
                if (!got) chk("ack_unexpected", 1'b0, cyc, -1);
                else begin
                    chk("ack_cycle", cyc == e.cyc, cyc, e.cyc);
                    chk("pass_done", int'(bus.pass_done_o) == e.a, int'(bus.pass_done_o), e.a);
                end
            end else if (bus.pass_done_o) begin
                chk("pass_done_without_ack", 1'b0, 1, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.start_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.n_active_cols_i = 5'd16;
        bus.n_pixels_i = 10'd2;

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy_o == 1'b0, int'(bus.busy_o), 0);
        chk("rst_reg_rst", reg_rst == 1'b1, int'(reg_rst), 1);
        chk("rst_wr_en_a", wr_en_a == 1'b0, int'(wr_en_a), 0);
        chk("rst_wr_en_b", wr_en_b == 1'b0, int'(wr_en_b), 0);
        chk("rst_sel_ld", sel_ld == 1'b0, int'(sel_ld), 0);
        chk("rst_reg_wr_en", reg_wr_en == 1'b0, int'(reg_wr_en), 0);
        chk("rst_ack", bus.data_ack_o == 1'b0, int'(bus.data_ack_o), 0);
        chk("rst_sel1", sel1 == '0, int'(sel1), 0);
        chk("rst_sel2", sel2 == '0, int'(sel2), 0);
        chk("rst_addr_a", addr_a == '0, int'(addr_a), 0);
        chk("rst_addr_b", addr_b == '0, int'(addr_b), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reg_rst_released", reg_rst == 1'b0, int'(reg_rst), 0);

        run_pass(16, 2, 0);   // pixel 0: addresses 0..15
        run_pass(16, 2, 0);   // pixel 1: addresses 16..31, pass_done
        run_pass(5, 2, 0);    // only columns 0..4 written
        run_pass(16, 2, 4);   // stray start during SWEEP
        run_pass(3, 0, 0);    // zero pixel count acts as one
        run_pass(0, 0, 0);    // no active columns: no writes

        // Clear with start also high.
        @(negedge clk);
        bus.n_active_cols_i = 5'd16;
        bus.n_pixels_i = 10'd3;
        bus.clear_i = 1'b1;
        bus.start_i = 1'b1;
        c0 = cyc;
`ifdef OUTPUT_ACCUM_CTRL_CLEAR_EN
        for (int i = 0; i < 48; i++) q_wb.push_back(mk(c0 + 1 + i, i, 0, 0));
        pix_m = 0;
`else
        push_pass(c0, 16, 3);
`endif
        @(negedge clk);
        bus.clear_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (60) @(negedge clk);
        chk("idle_after_clear", bus.busy_o == 1'b0, int'(bus.busy_o), 0);

        // Reset mid-SWEEP aborts the pass and returns pix to 0.
        run_pass(16, 4, 0);
        @(negedge clk);
        bus.start_i = 1'b1;
        c0 = cyc;
        push_pass(c0, 16, 4);
        @(negedge clk);
        bus.start_i = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        chk("pre_reset_sweep", sel_ld == 1'b1 && wr_en_a == 1'b1, int'({sel_ld, wr_en_a}), 3);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy_o == 1'b0, int'(bus.busy_o), 0);
        chk("midrst_wr_en_a", wr_en_a == 1'b0, int'(wr_en_a), 0);
        chk("midrst_wr_en_b", wr_en_b == 1'b0, int'(wr_en_b), 0);
        chk("midrst_reg_rst", reg_rst == 1'b1, int'(reg_rst), 1);
        chk("midrst_sel_ld", sel_ld == 1'b0, int'(sel_ld), 0);
        flush();
        pix_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_pass(16, 4, 0);   // restarts at pixel 0

        repeat (3) @(negedge clk);
        chk("left_sel", q_sel.size() == 0, q_sel.size(), 0);
        chk("left_capture", q_cap.size() == 0, q_cap.size(), 0);
        chk("left_wr_a", q_wa.size() == 0, q_wa.size(), 0);
        chk("left_wr_b", q_wb.size() == 0, q_wb.size(), 0);
        chk("left_ack", q_ack.size() == 0, q_ack.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/output_accum_ctrl.md
OUTPUT_ACCUM_CTRL -- requirements
Module: output_accum_ctrl

Interface
REQ-001 Parameters SHALL be N_COLS_ARRAY (16, array columns), NUMBER_MUX_OUT_1 (4, first-level mux count), NUMBER_INPUT_MUX_OUT_1 (ceil(N_COLS_ARRAY/NUMBER_MUX_OUT_1), inputs per mux), SEL_WIDTH_MUX_OUT_1 ($clog2(1+NUMBER_INPUT_MUX_OUT_1)), SEL_WIDTH_MUX_OUT_2 ($clog2(NUMBER_MUX_OUT_1)), BRAM_ADDR_WIDTH (15), PIX_WIDTH (10, pixel counter width).
REQ-002 Clock and reset SHALL be: clk_i in 1 clock; sel_mux_rst_i in 1, asynchronous, active-high reset.
REQ-003 Inputs SHALL be: start_i 1 (column results on data bus valid, begin accumulate); n_active_cols_i $clog2(N_COLS_ARRAY+1) (columns holding real filters); n_pixels_i PIX_WIDTH (output pixels per pass); clear_i 1 (begin BRAM clear, macro-gated).
REQ-004 Outputs SHALL be: sel_mux_out_1_o SEL_WIDTH_MUX_OUT_1; sel_mux_out_2_o SEL_WIDTH_MUX_OUT_2; sel_mux_ld_o 1; reg_rst_o 1; reg_wr_en_o 1; bram_wr_en_a_o 1; bram_wr_en_b_o 1; bram_addr_a_o BRAM_ADDR_WIDTH (write/accumulate port); bram_addr_b_o BRAM_ADDR_WIDTH (read/clear port); busy_o 1; data_ack_o 1 (data bus may change); pass_done_o 1 (one-cycle pulse).

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, LOAD, CAPTURE, SWEEP, DRAIN.
REQ-006 IDLE: start_i=1 -> LOAD with s1=1; clear_i=1 (macro on) -> CLEAR; both high -> CLEAR takes priority, start_i ignored.
REQ-007 LOAD (1 cycle): sel_mux_ld_o=1, sel_mux_out_1_o=s1, sel_mux_out_2_o=0; -> CAPTURE.
REQ-008 CAPTURE (1 cycle): reg_wr_en_o=1; g=0; -> SWEEP.
REQ-009 SWEEP (NUMBER_MUX_OUT_1 cycles): each cycle sel_mux_ld_o=1, sel_mux_out_1_o=s1, sel_mux_out_2_o=g, bram_addr_b_o=pix*N_COLS_ARRAY+col with col=g*NUMBER_INPUT_MUX_OUT_1+(s1-1); g increments.
REQ-010 Write SHALL lag read by exactly one cycle: cycle after a SWEEP slot, bram_addr_a_o=that slot's address, bram_wr_en_a_o=1 only if col<n_active_cols_i.
REQ-011 After last g: s1<NUMBER_INPUT_MUX_OUT_1 -> s1+1, LOAD (lagged write of last slot overlaps LOAD); else -> DRAIN.
REQ-012 DRAIN (1 cycle): final lagged write; data_ack_o=1; pix increments; pix==n_pixels_i-1 before increment -> pix=0, pass_done_o=1; -> IDLE.
REQ-013 Per-start latency SHALL be NUMBER_INPUT_MUX_OUT_1*(NUMBER_MUX_OUT_1+2)+1 cycles start_i to data_ack_o (25 for defaults).
REQ-014 start_i outside IDLE SHALL be ignored; upstream holds data bus stable until data_ack_o.
REQ-015 Address arithmetic SHALL be unsigned, truncated to BRAM_ADDR_WIDTH; n_pixels_i*N_COLS_ARRAY <= 2**BRAM_ADDR_WIDTH is a usage constraint, no wrap detection.
REQ-016 n_pixels_i=0 SHALL behave as 1; n_active_cols_i=0 SHALL run full sequence with no writes.
REQ-017 busy_o=1 in every state except IDLE; bram_wr_en_b_o=0 outside CLEAR; sel_mux_out_1_o value 0 (zero input) never issued in SWEEP.

Reset
REQ-018 sel_mux_rst_i SHALL force IDLE, s1=1, g=0, pix=0, all enables/strobes 0, selects 0, addresses 0, reg_rst_o=1 while asserted.
REQ-019 Reset mid-pass SHALL abort immediately; a partially written pixel is not repaired.
REQ-020 reg_rst_o SHALL be 0 from the first clock edge after reset release.

Configuration
REQ-021 Macro OUTPUT_ACCUM_CTRL_CLEAR_EN defined: CLEAR state sweeps bram_addr_b_o 0..n_pixels_i*N_COLS_ARRAY-1 one per cycle with bram_wr_en_b_o=1 (zero writes), then pix=0, -> IDLE, no pass_done_o.
REQ-022 Macro undefined: CLEAR state absent, clear_i ignored, bram_wr_en_b_o tied 0.

Structure
REQ-023 Shared package output_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-024 One sub-module, output_addr_gen (pix/col -> address, one-cycle write-lag register), is natural; rest in one FSM module.

Verification
REQ-025 Reset: assert sel_mux_rst_i mid-SWEEP -> same cycle busy_o=0, all wr_en 0, reg_rst_o=1.
REQ-026 Defaults, n_active_cols_i=16, n_pixels_i=2, start_i at pix 0 -> 16 port-A writes, addresses 0..15, each one cycle after matching port-B read, data_ack_o 25 cycles after start.
REQ-027 n_active_cols_i=5 -> only cols 0..4 written (5 writes), selects still swept for all 16 slots.
REQ-028 Two starts with n_pixels_i=2 -> second pass writes addresses 16..31, pass_done_o pulses once at its DRAIN, pix back to 0.
REQ-029 Macro on, clear_i with start_i both high, n_pixels_i=3 -> 48 port-B zero writes 0..47, start ignored; macro off -> no port-B writes.
REQ-030 start_i pulsed during SWEEP -> ignored, exactly one accumulate sequence executed.
